if_stage: RTL
=============

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 The block SHALL have one clock and one reset; the reset is synchronous and active-low.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-005 stall  input  1  from hazard unit; 1 = the downstream IF/ID register holds.
REQ-006 flush  input  1  branch/jump taken; discard in-flight and held fetches.
REQ-007 redirect_pc  input  32  new fetch address, valid when flush=1.
REQ-008 imem_req  output  1  instruction memory request.
REQ-009 imem_addr  output  32  request address, word aligned.
REQ-010 imem_gnt  input  1  request accepted in the same cycle as imem_req=1.
REQ-011 imem_rvalid  input  1  response valid, at least 1 cycle after gnt.
REQ-012 imem_rdata  input  32  fetched instruction.
REQ-013 if_valid  output  1  registered; if_pc/if_instr hold a live instruction.
REQ-014 if_pc  output  32  registered PC of if_instr.
REQ-015 if_instr  output  32  registered instruction to IF/ID.

Function
REQ-016 The block SHALL keep one outstanding request at most, using FSM states REQ, WAIT and SKID.
REQ-017 In REQ with stall=0, imem_req=1 and imem_addr=pc; on imem_gnt it SHALL set pc<=pc+4 (mod 2^32) and go to WAIT.
REQ-018 In REQ with stall=1, imem_req=0 and pc holds.
REQ-019 In WAIT, imem_req=0; on imem_rvalid with stall=0 it SHALL load if_valid=1, if_instr=imem_rdata and if_pc=request address, then go to REQ.
REQ-020 In WAIT, on imem_rvalid with stall=1, the response SHALL be captured into a 1-entry skid buffer, the outputs hold, and the FSM goes to SKID.
REQ-021 In SKID, on stall=0 the skid contents SHALL move to the outputs and the FSM goes to REQ; no request is issued in SKID.
REQ-022 With stall=0 and no response delivered, if_valid SHALL be cleared on the next edge (bubble).
REQ-023 With stall=1 and flush=0, if_valid/if_pc/if_instr SHALL hold unchanged.
REQ-024 flush SHALL take priority over stall and rvalid: pc<=redirect_pc and if_valid<=0, and the skid buffer is emptied.
REQ-025 A flush in REQ goes to REQ; a flush in SKID goes to REQ.
REQ-026 A flush in WAIT without rvalid SHALL set drop, and the next rvalid is discarded.
REQ-027 If flush and rvalid occur in the same cycle, the response SHALL be discarded and the FSM goes to REQ.
REQ-028 A flush asserted in the same cycle as imem_gnt: the granted request SHALL be dropped on response, and pc takes redirect_pc, not pc+4.
REQ-029 redirect_pc[1:0] SHALL be forced to 2'b00.

Reset
REQ-030 When rst_n=0, the block SHALL set pc=RESET_PC, FSM=REQ, drop=0, skid empty, if_valid=0, if_pc=0, if_instr=32'h0000_0013 (NOP), and imem_req=0 during that cycle.
REQ-031 Reset mid-WAIT: a later stale rvalid SHALL be ignored; the drop flag is set on reset exit only if a request was granted but not yet answered.

Configuration
REQ-032 With IF_PERF_CNT_EN defined, the block SHALL add output stall_cnt (32), which counts cycles with stall=1 and flush=0, wraps at 2^32 and resets to 0.
REQ-033 Without IF_PERF_CNT_EN, the port and the counter SHALL be absent.

Verification
REQ-034 Reset release, gnt same cycle, rvalid +1 with stall=0 -> if_pc=0,4,8 on successive fetches, if_valid=1, instr matches memory.
REQ-035 rvalid while stall=1 for 3 cycles -> outputs hold prior instr; on stall=0 the skid instr appears with its PC, and the next req addr is PC+4.
REQ-036 Flush with redirect_pc=32'h0000_0100 while in WAIT -> next rvalid dropped (if_valid=0), then fetch addr 0x100.
REQ-037 Flush and rvalid in the same cycle, with redirect_pc=0x203 -> response dropped, imem_addr=0x200.
REQ-038 rst_n=0 mid-SKID -> if_valid=0, if_instr=0x00000013, imem_addr=RESET_PC after release.
REQ-039 With IF_PERF_CNT_EN defined, 5 stall cycles including one with flush -> stall_cnt=4.

Source files
------------

// File: rtl/if_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
// The master side issues requests; the slave side is the memory.
interface if_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: one outstanding imem request, a 1-entry skid
// buffer for responses that arrive while IF/ID is stalled, and flush/redirect
// handling that discards in-flight responses.
// Optional feature: define IF_PERF_CNT_EN to add the stall_cnt output.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic [31:0]       redirect_pc,
  if_stage_if.master        imem,
  output logic              if_valid,
  output logic [31:0]       if_pc,
  output logic [31:0]       if_instr
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);

  localparam logic [31:0] NOP        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_A = RESET_PC & 32'hFFFF_FFFC;

  // SKID state itself marks the skid buffer as occupied.
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_SKID = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] req_pc;
  logic        drop;
  logic [31:0] skid_instr;
  logic [31:0] skid_pc;

  logic [31:0] redirect_aligned;
  logic        req_fire;

  assign redirect_aligned = redirect_pc & 32'hFFFF_FFFC;

  // Request only from REQ, not stalled, not in reset, and not while a stale
  // response is still owed to us (drop set outside WAIT after a reset).
  assign imem.imem_req  = rst_n && (state == S_REQ) && !stall && !drop;
  assign imem.imem_addr = pc;
  assign req_fire       = imem.imem_req && imem.imem_gnt;

  // Fetch FSM, PC, skid buffer and registered IF/ID outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_REQ;
      pc         <= RESET_PC_A;
      req_pc     <= '0;
      // A granted but unanswered request survives reset: its late response
      // must be discarded, and no new request may go out until it arrives.
      drop       <= ((state == S_WAIT) || drop) && !imem.imem_rvalid;
      skid_instr <= NOP;
      skid_pc    <= '0;
      if_valid   <= 1'b0;
      if_pc      <= '0;
      if_instr   <= NOP;
    end else if (flush) begin
      pc       <= redirect_aligned;
      if_valid <= 1'b0;
      case (state)
        S_REQ: begin
          if (req_fire) begin
            state <= S_WAIT;
            drop  <= 1'b1;
          end else begin
            state <= S_REQ;
            if (drop && imem.imem_rvalid) drop <= 1'b0;
          end
        end
        S_WAIT: begin
          if (imem.imem_rvalid) begin
            state <= S_REQ;
            drop  <= 1'b0;
          end else begin
            drop  <= 1'b1;
          end
        end
        default: state <= S_REQ;
      endcase
    end else begin
      case (state)
        S_REQ: begin
          if (drop && imem.imem_rvalid) drop <= 1'b0;
          if (!stall) if_valid <= 1'b0;
          if (req_fire) begin
            req_pc <= pc;
            pc     <= pc + 32'd4;
            state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem.imem_rvalid) begin
            if (drop) begin
              drop  <= 1'b0;
              state <= S_REQ;
              if (!stall) if_valid <= 1'b0;
            end else if (!stall) begin
              if_valid <= 1'b1;
              if_instr <= imem.imem_rdata;
              if_pc    <= req_pc;
              state    <= S_REQ;
            end else begin
              skid_instr <= imem.imem_rdata;
              skid_pc    <= req_pc;
              state      <= S_SKID;
            end
          end else if (!stall) begin
            if_valid <= 1'b0;
          end
        end
        S_SKID: begin
          if (!stall) begin
            if_valid <= 1'b1;
            if_instr <= skid_instr;
            if_pc    <= skid_pc;
            state    <= S_REQ;
          end
        end
        default: state <= S_REQ;
      endcase
    end
  end

`ifdef IF_PERF_CNT_EN
  // Count cycles the pipeline is held by the hazard unit (flush cycles excluded).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stall && !flush) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule
